operand_entry: RTL
==================

# operand_entry

Input front end for the binary calculator. Turns raw push-button and slide-switch activity into clean, one-time register loads and display-select changes. It synchronises and debounces the four buttons and collects a button chord until every button is released. On release it commits exactly one action: load r0, r1 or rs from the switches, or select what the display multiplexer shows. It sits between the board I/O pins and the ALU/display path. Its outputs drive the ALU operand inputs, the op-select input and the display mux select directly.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable `clk` cycles a synchronised button level must hold before it is accepted (≥2).
- clk  input  1  system clock (undivided board clock).
- rst_n  input  1  asynchronous, active-low reset.
- switch  input  12  raw slide switches (asynchronous to clk).
- bt  input  4  raw push buttons, active-high (asynchronous to clk).
- r0  output  12  operand A register to the ALU.
- r1  output  12  operand B register to the ALU.
- rs  output  4  ALU operation select register.
- muxsel  output  2  display source: 0 ALU result, 1 r0, 2 r1, 3 rs.
- load_pulse  output  1  high for exactly one cycle when r0, r1 or rs is written.
- bad_chord  output  1  sticky flag: the last committed chord was invalid.

## Operation
- Synchronisers: `bt` and `switch` each pass through two flip-flops. The result is `bt_s` and `sw_s`.
- Debounce, per button bit, with a stable bit `db[i]` and a counter:
  - If `bt_s[i] == db[i]`, the counter resets to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, `db[i] <= bt_s[i]` and the counter resets to 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `db`.
- Chord FSM states:
  - IDLE: `acc <= 0`. Go to COLLECT when `db != 0`.
  - COLLECT: `acc <= acc | db` every cycle. Go to COMMIT when `db == 0`.
  - COMMIT: decode `acc` and perform one action, then return to IDLE. Lasts exactly one cycle.
- COMMIT decode:
  - 4'b0001 → muxsel=1; 4'b0010 → muxsel=2; 4'b0100 → muxsel=3; 4'b1000 → muxsel=0.
  - 4'b1001 → r0 <= sw_s; load_pulse.
  - 4'b1010 → r1 <= sw_s; load_pulse.
  - 4'b1100 → rs <= sw_s[3:0]; load_pulse.
  - All valid chords clear bad_chord.
  - Any other value (including three or more buttons) → no register or muxsel change; bad_chord <= 1.
- Load chords do not change muxsel. The switch value used is `sw_s` as sampled in the COMMIT cycle.
- Button presses during COMMIT are not lost. `db` is sampled again in IDLE on the next cycle.

## Timing
- Reset values: r0=0, r1=0, rs=0, muxsel=0, load_pulse=0, bad_chord=0, all `db`=0, counters=0, FSM=IDLE, `acc`=0.
- Press latency: a raw level stable from edge T appears in `bt_s` at T+2 and in `db` at T+2+DEBOUNCE_CYCLES.
- Commit latency:
  - `db` becomes 0 at edge E.
  - The FSM enters COMMIT at E+1.
  - r0/r1/rs/muxsel/bad_chord update and load_pulse rises at E+2.
  - load_pulse falls at E+3.
- Raw release to register update: 4+DEBOUNCE_CYCLES cycles.
- Staggered release is harmless. COMMIT waits for all bits of `db` to be 0, and `acc` keeps every button seen during the chord.
- Reset mid-chord: all state is cleared at once and the partial chord is discarded.
  - A button still held when rst_n deasserts is debounced as a fresh press.
  - It commits on its release.
- Any reset assertion returns every output to its reset value asynchronously.

## Test plan
(All with DEBOUNCE_CYCLES=4.)
- Reset → r0=r1=0, rs=0, muxsel=0, load_pulse=0, bad_chord=0.
- Load r0: switch=200; press bt[3] then bt[0] (bt=9); hold 10 cycles; release both.
  - Required: r0=200 exactly 8 cycles after the raw release.
  - load_pulse high for 1 cycle; muxsel unchanged.
- Full entry sequence:
  - Load rs=0 (bt=12, switch=0), r0=200 (bt=9), r1=40 (bt=10), each chord held and released.
  - Required: r0=200, r1=40, rs=0, and exactly 3 load_pulses.
  - Then press/release bt=2 → muxsel=2.
- Bounce rejection: toggle bt[0] raw every 2 cycles for 20 cycles, then hold 0.
  - Required: `db` never changes; no commit; outputs unchanged.
- Invalid chord: press bt=4'b0011 and release.
  - Required: bad_chord=1; r0/r1/rs/muxsel unchanged.
  - A following valid bt=1 press clears bad_chord and sets muxsel=1.
- Reset mid-chord: switch=7; hold bt=9; assert rst_n low for 3 cycles while held; deassert; then release.
  - Required: r0 stays 0 during the reset.
  - r0=7 after the release, because the post-reset press is debounced as a new chord.

Source files
------------

// File: rtl/operand_entry.sv
// Calculator input front end. It synchronises and debounces the push buttons, collects a
// button chord until every button is released, and then commits one register load or display select.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] switch,
  input  logic [3:0]  bt,
  output logic [11:0] r0,
  output logic [11:0] r1,
  output logic [3:0]  rs,
  output logic [1:0]  muxsel,
  output logic        load_pulse,
  output logic        bad_chord
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  logic [3:0]    bt_m, bt_s;
  logic [11:0]   sw_m, sw_s;
  logic [3:0]    db;
  logic [CW-1:0] cnt [4];
  state_t        state, state_next;
  logic [3:0]    acc, acc_next;

  logic          ld_r0, ld_r1, ld_rs, mux_wr, chord_ok;
  logic [1:0]    mux_val;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_m <= '0;
      bt_s <= '0;
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample the pre-edge values, so this stays a two-stage shift.
      bt_m <= bt;
      bt_s <= bt_m;
      sw_m <= switch;
      sw_s <= sw_m;
    end
  end

  // A button level is accepted only after it differs from db for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      // NOTE: these counters are control state, not a data memory, so every entry is cleared on reset.
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bt_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= bt_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    acc_next   = acc;
    case (state)
      IDLE: begin
        acc_next = '0;
        if (db != '0) state_next = COLLECT;
      end
      COLLECT: begin
        acc_next = acc | db;
        if (db == '0) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chord decode. The decode is only acted on in the single COMMIT cycle.
  always_comb begin
    ld_r0    = 1'b0;
    ld_r1    = 1'b0;
    ld_rs    = 1'b0;
    mux_wr   = 1'b0;
    mux_val  = 2'd0;
    chord_ok = 1'b1;
    case (acc)
      4'b0001: begin mux_wr = 1'b1; mux_val = 2'd1; end
      4'b0010: begin mux_wr = 1'b1; mux_val = 2'd2; end
      4'b0100: begin mux_wr = 1'b1; mux_val = 2'd3; end
      4'b1000: begin mux_wr = 1'b1; mux_val = 2'd0; end
      4'b1001: ld_r0 = 1'b1;
      4'b1010: ld_r1 = 1'b1;
      4'b1100: ld_rs = 1'b1;
      default: chord_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0         <= '0;
      r1         <= '0;
      rs         <= '0;
      muxsel     <= '0;
      load_pulse <= 1'b0;
      bad_chord  <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      if (state == COMMIT) begin
        bad_chord  <= ~chord_ok;
        load_pulse <= ld_r0 | ld_r1 | ld_rs;
        if (ld_r0)  r0     <= sw_s;
        if (ld_r1)  r1     <= sw_s;
        if (ld_rs)  rs     <= sw_s[3:0];
        if (mux_wr) muxsel <= mux_val;
      end
    end
  end

endmodule
